// File: rtl/mt_pkg.sv
// Shared MT19937 definitions used by the twister core and its stream buffer.
// Contents: word width, recurrence constants N/M, twist matrix, tempering
// masks and shifts, the mt_word_t type and a tempering helper.
package mt_pkg;

    localparam int unsigned MT_WORD_W = 32;
    localparam int unsigned MT_N      = 624;
    localparam int unsigned MT_M      = 397;

    localparam logic [31:0] MT_MATRIX_A = 32'h9908_B0DF;
    localparam logic [31:0] MT_UPPER    = 32'h8000_0000;
    localparam logic [31:0] MT_LOWER    = 32'h7FFF_FFFF;
    localparam logic [31:0] MT_MASK_B   = 32'h9D2C_5680;
    localparam logic [31:0] MT_MASK_C   = 32'hEFC6_0000;

    localparam int unsigned MT_SHIFT_U = 11;
    localparam int unsigned MT_SHIFT_S = 7;
    localparam int unsigned MT_SHIFT_T = 15;
    localparam int unsigned MT_SHIFT_L = 18;

    typedef logic [MT_WORD_W-1:0] mt_word_t;

    // Standard MT19937 output tempering of one state word.
    function automatic mt_word_t mt_temper(input mt_word_t y_in);
        mt_word_t y;
        y = y_in;
        y = y ^ (y >> MT_SHIFT_U);
        y = y ^ ((y << MT_SHIFT_S) & MT_MASK_B);
        y = y ^ ((y << MT_SHIFT_T) & MT_MASK_C);
        y = y ^ (y >> MT_SHIFT_L);
        return y;
    endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// Synchronous first-word-fall-through FIFO with register-array storage.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   i_push, i_wdata   write request and data (ignored when full)
//   i_pop             advance head (ignored when empty)
//   o_rdata           head word, valid whenever o_empty=0
//   o_empty, o_full   occupancy flags
//   o_level           occupancy 0..DEPTH
module sync_fifo_fwft #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_empty,
    output logic                     o_full,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_level;

    logic w_push;
    logic w_pop;
    logic w_empty;
    logic w_full;

    assign w_empty = (r_level == '0);
    assign w_full  = (r_level == FULL_LVL);
    assign w_push  = i_push & ~w_full;
    assign w_pop   = i_pop & ~w_empty;

    // Pointers wrap naturally since DEPTH is a power of two; level is kept
    // separately so full and empty are unambiguous.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // Storage needs no reset; contents are only observed once written.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= i_wdata;
    end

    assign o_rdata = r_mem[r_rptr];
    assign o_empty = w_empty;
    assign o_full  = w_full;
    assign o_level = r_level;

endmodule

// File: rtl/mt_stream_buffer.sv
// Adapts the Mersenne-twister core's ready/trig/r_num pulse interface to a
// valid/ready stream, prefetching words into an FWFT FIFO so consumers do not
// see the core's regeneration gaps. A settle counter enforces the core's
// read-settle time between successive trig pulses.
// Ports:
//   clk, rst     clock, synchronous active-high reset (shared with the core)
//   mt_ready     core holds a valid tempered word on mt_num
//   mt_num       tempered word from the core
//   mt_trig      one-cycle pulse advancing the core; word sampled same cycle
//   m_valid      head word available
//   m_data       head word
//   m_ready      consumer accepts head word this cycle
//   level        FIFO occupancy 0..DEPTH
module mt_stream_buffer
    import mt_pkg::*;
#(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned SETTLE = 2,
    // Must match the core output width.
    parameter int unsigned WORD_W = MT_WORD_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     mt_ready,
    input  logic [WORD_W-1:0]        mt_num,
    output logic                     mt_trig,
    output logic                     m_valid,
    output logic [WORD_W-1:0]        m_data,
    input  logic                     m_ready,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned SW = $clog2(SETTLE + 1);

    logic [SW-1:0] r_scnt;

    logic w_cap;
    logic w_pop;
    logic w_empty;
    logic w_full;

    // Full is taken from the registered level, so a same-cycle pop never
    // unblocks a capture. Trig is suppressed while reset is held.
    assign w_cap = mt_ready & (r_scnt == '0) & ~w_full & ~rst;
    assign w_pop = ~w_empty & m_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_scnt <= '0;
        end else if (w_cap) begin
            r_scnt <= SW'(SETTLE);
        end else if (r_scnt != '0) begin
            r_scnt <= r_scnt - 1'b1;
        end
    end

    sync_fifo_fwft #(
        .DEPTH (DEPTH),
        .WIDTH (WORD_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_cap),
        .i_wdata (mt_num),
        .i_pop   (w_pop),
        .o_rdata (m_data),
        .o_empty (w_empty),
        .o_full  (w_full),
        .o_level (level)
    );

    assign mt_trig = w_cap;
    assign m_valid = ~w_empty;

endmodule

// File: tb/tb_mt_stream_buffer.sv
module tb_mt_stream_buffer;
    import mt_pkg::*;

    localparam int DEPTH  = 16;
    localparam int SETTLE = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mt_ready = 1'b0;
    logic [31:0] mt_num;
    logic        mt_trig;
    logic        m_valid;
    logic [31:0] m_data;
    logic        m_ready = 1'b0;
    logic [4:0]  level;

    always #5 clk = ~clk;

    mt_stream_buffer #(
        .DEPTH  (DEPTH),
        .SETTLE (SETTLE),
        .WORD_W (32)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .mt_ready (mt_ready),
        .mt_num   (mt_num),
        .mt_trig  (mt_trig),
        .m_valid  (m_valid),
        .m_data   (m_data),
        .m_ready  (m_ready),
        .level    (level)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- stub core ----------------
    logic [31:0] stub_cnt;
    logic [31:0] mt_words [16];
    logic        use_mt = 1'b0;

    always @(posedge clk) begin
        if (rst) stub_cnt <= 32'd1;
        else if (mt_trig) stub_cnt <= stub_cnt + 32'd1;
    end

    assign mt_num = use_mt ? mt_words[4'(stub_cnt - 32'd1)] : stub_cnt;

    // ---------------- reference model / monitors ----------------
    logic [31:0] q[$];
    logic [31:0] rx[$];
    int gap = SETTLE + 1;
    int cyc = 0;
    int last_trig = -100;
    int trig_cnt = 0;
    bit exp_cap;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            chk("rst_trig", mt_trig, 0);
            q.delete();
            gap = SETTLE + 1;
            last_trig = -100;
        end else begin
            exp_cap = mt_ready && (gap > SETTLE) && (q.size() < DEPTH);
            chk("m_trig", mt_trig, exp_cap);
            chk("m_valid", m_valid, q.size() != 0);
            chk("m_level", level, q.size());
            if (q.size() != 0) chk("m_data", m_data, q[0]);
            chk("a_trig_ready", mt_trig & ~mt_ready, 0);
            chk("a_level_max", level > DEPTH, 0);
            if (mt_trig) begin
                chk("a_spacing", (cyc - last_trig) > SETTLE, 1);
                last_trig = cyc;
                trig_cnt++;
            end
            if (m_valid && m_ready) rx.push_back(m_data);
            if (q.size() != 0 && m_ready) void'(q.pop_front());
            if (exp_cap) q.push_back(mt_num);
            gap = exp_cap ? 1 : ((gap < 1000) ? gap + 1 : gap);
        end
    end

    // ---------------- directed vectors ----------------
    typedef struct {
        logic        mt_rdy;
        logic        m_rdy;
        logic        trig;
        logic        valid;
        logic [31:0] data;
        logic [4:0]  lvl;
    } vec_t;

    function automatic vec_t mkv(input logic a, input logic b, input logic t, input logic v,
                                 input logic [31:0] d, input logic [4:0] l);
        vec_t r;
        r.mt_rdy = a; r.m_rdy = b; r.trig = t; r.valid = v; r.data = d; r.lvl = l;
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        vec_t vec [9];
        logic [31:0] st [MT_N];
        logic [31:0] y;
        int base;
        int tbase;
        int vrun;
        int vtot;
        bit ok;
        bit found;
        int drop_left;
        int bias;

        // MT19937 reference stream, seed 5489.
        st[0] = 32'd5489;
        for (int i = 1; i < int'(MT_N); i++)
            st[i] = 32'd1812433253 * (st[i-1] ^ (st[i-1] >> 30)) + 32'(i);
        for (int i = 0; i < int'(MT_N); i++) begin
            y = (st[i] & MT_UPPER) | (st[(i + 1) % MT_N] & MT_LOWER);
            st[i] = st[(i + MT_M) % MT_N] ^ (y >> 1) ^ (y[0] ? MT_MATRIX_A : 32'd0);
        end
        for (int k = 0; k < 16; k++) mt_words[k] = mt_temper(st[k]);

        // Phase 1: one word every SETTLE+1 cycles, FWFT latency of one cycle.
        vec[0] = mkv(1, 1, 1, 0, 32'd0, 5'd0);
        vec[1] = mkv(1, 1, 0, 1, 32'd1, 5'd1);
        vec[2] = mkv(1, 1, 0, 0, 32'd0, 5'd0);
        vec[3] = mkv(1, 1, 1, 0, 32'd0, 5'd0);
        vec[4] = mkv(1, 1, 0, 1, 32'd2, 5'd1);
        vec[5] = mkv(1, 1, 0, 0, 32'd0, 5'd0);
        vec[6] = mkv(1, 1, 1, 0, 32'd0, 5'd0);
        vec[7] = mkv(1, 1, 0, 1, 32'd3, 5'd1);
        vec[8] = mkv(1, 1, 0, 0, 32'd0, 5'd0);
        mt_ready = 1'b1;
        m_ready  = 1'b1;
        do_reset();
        for (int k = 0; k < 9; k++) begin
            mt_ready = vec[k].mt_rdy;
            m_ready  = vec[k].m_rdy;
            @(negedge clk);
            chk($sformatf("v%0d_trig", k), mt_trig, vec[k].trig);
            chk($sformatf("v%0d_valid", k), m_valid, vec[k].valid);
            chk($sformatf("v%0d_level", k), level, vec[k].lvl);
            if (vec[k].valid) chk($sformatf("v%0d_data", k), m_data, vec[k].data);
            step();
        end

        // Phase 2: fill with consumer stalled, then drain in order.
        mt_ready = 1'b1;
        m_ready  = 1'b0;
        do_reset();
        tbase = trig_cnt;
        repeat (200) step();
        chk("p2_trig_count", trig_cnt - tbase, 16);
        chk("p2_level_full", level, 16);
        base = rx.size();
        m_ready = 1'b1;
        repeat (60) step();
        chk("p2_rx_count", rx.size() >= base + 17, 1);
        ok = 1'b1;
        for (int i = 0; i < 17; i++)
            if (rx.size() > base + i && rx[base + i] !== 32'(i + 1)) ok = 1'b0;
        chk("p2_order", ok, 1);

        // Phase 3: core in GEN with a full FIFO; consumer drains without stall.
        m_ready = 1'b0;
        repeat (60) step();
        chk("p3_full", level, 16);
        mt_ready = 1'b0;
        m_ready  = 1'b1;
        base = rx.size();
        vrun = 0;
        vtot = 0;
        for (int i = 0; i < 620; i++) begin
            @(negedge clk);
            if (m_valid) begin
                vtot++;
                if (vrun == i) vrun++;
            end
            step();
        end
        chk("p3_valid_run", vrun, 16);
        chk("p3_valid_total", vtot, 16);
        chk("p3_rx_count", rx.size() - base, 16);
        mt_ready = 1'b1;
        @(negedge clk);
        chk("p3_refill_trig", mt_trig, 1);
        step();

        // Phase 4: level 1 with simultaneous capture and pop.
        mt_ready = 1'b1;
        m_ready  = 1'b0;
        do_reset();
        step();
        mt_ready = 1'b0;
        repeat (4) step();
        chk("p4_level1", level, 1);
        mt_ready = 1'b1;
        m_ready  = 1'b1;
        @(negedge clk);
        chk("p4_cap_trig", mt_trig, 1);
        chk("p4_cap_data", m_data, 32'd1);
        step();
        mt_ready = 1'b0;
        m_ready  = 1'b0;
        @(negedge clk);
        chk("p4_after_level", level, 1);
        chk("p4_after_valid", m_valid, 1);
        chk("p4_after_data", m_data, 32'd2);
        step();

        // Phase 5: reset mid-stream with level=9 and settle count loaded.
        mt_ready = 1'b1;
        m_ready  = 1'b0;
        do_reset();
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (mt_trig && level == 5'd8) found = 1'b1;
            step();
        end
        chk("p5_found_level9", found, 1);
        chk("p5_level9", level, 9);
        rst = 1'b1;
        @(negedge clk);
        chk("p5_rst_trig", mt_trig, 0);
        step();
        rst = 1'b0;
        mt_ready = 1'b0;
        @(negedge clk);
        chk("p5_post_level", level, 0);
        chk("p5_post_valid", m_valid, 0);
        chk("p5_post_trig", mt_trig, 0);
        step();
        mt_ready = 1'b1;
        @(negedge clk);
        chk("p5_first_cap", mt_trig, 1);
        step();

        // Phase 6: randomized traffic against the model.
        drop_left = 0;
        for (int i = 0; i < 3000; i++) begin
            bias = (i < 1500) ? 1 : 3;
            if (drop_left > 0) begin
                mt_ready = 1'b0;
                drop_left--;
            end else if ($urandom_range(0, 99) < 3) begin
                drop_left = $urandom_range(10, 80);
                mt_ready = 1'b0;
            end else begin
                mt_ready = ($urandom_range(0, 9) != 0);
            end
            m_ready = ($urandom_range(0, 3) < bias);
            step();
        end

        // Phase 7: MT19937 reference words through the buffer.
        use_mt   = 1'b1;
        mt_ready = 1'b1;
        m_ready  = 1'b1;
        do_reset();
        base = rx.size();
        repeat (20) step();
        chk("p7_rx_count", rx.size() >= base + 2, 1);
        if (rx.size() >= base + 2) begin
            chk("p7_word0", rx[base], 32'hD091_BB5C);
            chk("p7_word1", rx[base + 1], 32'h22AE_9EF6);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mt_stream_buffer.md
Name: mt_stream_buffer

Overview:
- Sits directly downstream of the Mersenne-twister core.
- Converts the core's pulse interface (ready/trig/r_num) into a valid/ready stream.
- Prefetches tempered words into a small first-word-fall-through (FWFT) FIFO. This hides the core's ~N-cycle regeneration (GEN) gaps from consumers.
- Honours the core's read-settle time after every trig pulse.

Parameters:
- DEPTH, 16, FIFO capacity in 32-bit words; power of two, at least 2.
- SETTLE, 2, minimum cycles after a trig pulse before the next capture; at least 1.
- WORD_W, 32, word width; must equal the core output width.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- mt_ready  in  1  core has a valid tempered word on mt_num (core is in EXTR).
- mt_num  in  WORD_W  tempered word from the core (its r_num).
- mt_trig  out  1  single-cycle pulse that advances the core's extraction index.
- m_valid  out  1  FIFO head word available.
- m_data  out  WORD_W  FIFO head word; stable while m_valid=1 and m_ready=0.
- m_ready  in  1  consumer accepts the head word this cycle.
- level  out  $clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH.

Behaviour:
- Reset: m_valid=0, mt_trig=0, level=0, settle counter=0, FIFO pointers=0. m_data is don't-care while m_valid=0.
- Reset mid-stream: rst discards all buffered words and any in-flight settle count. The upstream core reseeds on the same rst.
- Settle counter scnt:
  - Loaded with SETTLE on every cycle where mt_trig=1.
  - Otherwise decrements to 0 and saturates there.
- Capture condition: cap = mt_ready & (scnt==0) & (level<DEPTH), evaluated on the registered level at the start of the cycle.
  - A pop in the same cycle does not unblock a full FIFO.
- On a cap cycle, in the same cycle:
  - mt_num is written to the FIFO tail.
  - mt_trig is driven combinationally from cap (mt_trig = cap), so the word is sampled in the cycle the pulse is issued.
- Back-to-back captures are at least SETTLE+1 cycles apart. Peak fill rate is 1/(SETTLE+1) words per cycle.
- If mt_ready drops, no capture occurs and scnt keeps counting down. Capture resumes on the first cycle with mt_ready=1 and scnt==0. There is no extra latency after GEN ends.
- Pop: pop = m_valid & m_ready; the head advances on the clock edge.
- FWFT latency: a word captured at edge t (FIFO previously empty) gives m_valid=1 and m_data equal to that word from cycle t+1.
- Simultaneous push and pop: level is unchanged and both pointers advance.
  - When level==1, the old head is consumed and the pushed word becomes the head next cycle. m_valid stays 1.
- Full (level==DEPTH): mt_trig is held 0. The core is never advanced, so no word is lost.
- Empty: m_valid=0; m_ready is ignored.
- Pointers are $clog2(DEPTH) bits and wrap naturally. level is tracked separately: +1 on push only, -1 on pop only.
- Ordering: words leave in exactly the order they were captured. No duplication, no skipping.
- Assertions (bench): mt_trig never high while mt_ready=0; never two trig pulses closer than SETTLE+1 cycles; level never exceeds DEPTH.

Decomposition:
- Package mt_pkg:
  - MT_WORD_W=32.
  - MT19937 constants N=624, M=397 and tempering masks, shared with the core.
  - Typedef mt_word_t.
- Sub-module sync_fifo_fwft (DEPTH, WIDTH):
  - Register-array storage, push/pop/level/empty/full.
  - Reusable elsewhere.
- The top level holds the settle counter, capture logic and stream glue.

Test Plan:
- Reset then stub core with mt_ready=1 and mt_num incrementing from 0x00000001 on each trig; m_ready=1 -> m_data sequence 1,2,3,..., one word every 3 cycles (SETTLE=2). First m_valid 1 cycle after first trig.
- m_ready=0, mt_ready=1 for 200 cycles -> level reaches 16 and saturates; mt_trig count exactly 16. Then m_ready=1 -> words 1..16 then 17.., none lost or duplicated.
- Stub drops mt_ready for 620 cycles (GEN) with FIFO at level 16, m_ready=1 -> consumer receives 16 words without stall. m_valid falls only after the FIFO drains; refill starts on the first cycle mt_ready returns.
- Level==1 with simultaneous cap and pop -> level stays 1, m_valid stays 1, next m_data is the newly captured word.
- rst asserted while level=9 and scnt=2 -> next cycle level=0, m_valid=0, mt_trig=0. First capture after release happens on the first cycle with mt_ready=1.
- Real MT core, seed 5489, m_ready=1 -> first two m_data 0xD091BB5C and 0x22AE9EF6, matching the MT19937 reference outputs.
